// File: rtl/boa_muldiv_iter.sv
// boa_muldiv_iter: iterative RISC-V M-extension multiply/divide unit.
// One operation in flight. Multiplies use shift-add over a double-width
// accumulator and divides use restoring division. Both work on operand
// magnitudes, and the sign is applied in a single FIX cycle at the end.
module boa_muldiv_iter #(
  parameter int width   = 32,
  parameter int mul_bpc = 4,
  parameter int div_bpc = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [2:0]       op,
  input  logic [width-1:0] lhs,
  input  logic [width-1:0] rhs,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [width-1:0] q_res
);

  localparam int cw = $clog2(width + 1);
  localparam logic [cw-1:0] MUL_STEPS = cw'(width / mul_bpc);
  localparam logic [cw-1:0] DIV_STEPS = cw'(width / div_bpc);
  localparam logic [cw-1:0] CNT_ONE   = cw'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [cw-1:0]      cnt;
  logic [2:0]         op_q;
  logic [width-1:0]   dvs;
  logic [2*width-1:0] acc;
  logic               neg_q;
  logic               dz_q;

  logic               is_div;
  logic               lhs_signed;
  logic               rhs_signed;
  logic               lhs_neg;
  logic               rhs_neg;
  logic [width-1:0]   lhs_mag;
  logic [width-1:0]   rhs_mag;
  logic               sign_flag;
  logic               div_zero;

  logic [width+mul_bpc-1:0] mul_sum;
  logic [2*width-1:0]       mul_next;
  logic [width:0]           trial;
  logic [width-1:0]         rem_w;
  logic [width-1:0]         quo_w;
  logic [2*width-1:0]       div_next;

  logic [2*width-1:0] prod_fix;
  logic [width-1:0]   rem_fix;
  logic [width-1:0]   quo_fix;
  logic [width-1:0]   fix_res;

  assign d_ready = (state == IDLE) && !flush;
  assign q_valid = (state == DONE);

  // Decode signedness and form operand magnitudes and the final sign flag.
  // REM follows the sign of lhs; everything else negates when the signs differ.
  always_comb begin
    is_div     = op[2];
    lhs_signed = is_div ? !op[0] : ((op == 3'd1) || (op == 3'd2));
    rhs_signed = is_div ? !op[0] : (op == 3'd1);
    lhs_neg    = lhs_signed && lhs[width-1];
    rhs_neg    = rhs_signed && rhs[width-1];
    lhs_mag    = lhs_neg ? -lhs : lhs;
    rhs_mag    = rhs_neg ? -rhs : rhs;
    sign_flag  = (is_div && op[1]) ? lhs_neg : (lhs_neg ^ rhs_neg);
    div_zero   = is_div && (rhs == '0);
  end

  // One multiply step. The low mul_bpc bits of acc select multiples of the
  // multiplicand, which are added into the upper half; the whole pair then
  // shifts right by mul_bpc.
  always_comb begin
    mul_sum = {{mul_bpc{1'b0}}, acc[2*width-1:width]};
    for (int i = 0; i < mul_bpc; i++) begin
      if (acc[i]) begin
        mul_sum = mul_sum + ({{mul_bpc{1'b0}}, dvs} << i);
      end
    end
    mul_next = {mul_sum, acc[width-1:mul_bpc]};
  end

  // One divide step of div_bpc restoring iterations. The upper half of acc
  // holds the partial remainder. The lower half shifts the dividend out and
  // the quotient bits in.
  always_comb begin
    rem_w = acc[2*width-1:width];
    quo_w = acc[width-1:0];
    trial = '0;
    for (int i = 0; i < div_bpc; i++) begin
      trial = {rem_w, quo_w[width-1]};
      quo_w = {quo_w[width-2:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial    = trial - {1'b0, dvs};
        quo_w[0] = 1'b1;
      end
      rem_w = trial[width-1:0];
    end
    div_next = {rem_w, quo_w};
  end

  // Sign correction and result selection used in the FIX cycle. On a divide
  // by zero, acc holds the raw lhs.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    rem_fix  = neg_q ? -acc[2*width-1:width] : acc[2*width-1:width];
    quo_fix  = neg_q ? -acc[width-1:0] : acc[width-1:0];
    fix_res  = '0;
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'd0) ? prod_fix[width-1:0] : prod_fix[2*width-1:width];
    end else if (dz_q) begin
      fix_res = op_q[1] ? acc[width-1:0] : '1;
    end else if (op_q[1]) begin
      fix_res = rem_fix;
    end else begin
      fix_res = quo_fix;
    end
  end

  // Control FSM and datapath registers. Flush overrides every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q_res <= '0;
      op_q  <= '0;
      dvs   <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            op_q  <= op;
            neg_q <= sign_flag;
            dz_q  <= div_zero;
            dvs   <= is_div ? rhs_mag : lhs_mag;
            if (div_zero) begin
              acc   <= {{width{1'b0}}, lhs};
              cnt   <= '0;
              state <= FIX;
            end else if (is_div) begin
              acc   <= {{width{1'b0}}, lhs_mag};
              cnt   <= DIV_STEPS;
              state <= RUN;
            end else begin
              acc   <= {{width{1'b0}}, rhs_mag};
              cnt   <= MUL_STEPS;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= op_q[2] ? div_next : mul_next;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= FIX;
          end
        end
        FIX: begin
          q_res <= fix_res;
          state <= DONE;
        end
        DONE: begin
          if (q_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
